// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, inverse S-box, GF(2^8) arithmetic and byte/row helpers shared by the cipher paths
package aes_pkg;
   localparam int NR_128 = 10;
   localparam int NR_192 = 12;
   localparam int NR_256 = 14;
   typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} inv_state_t;
   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX_TBL[2047-8*int'(b) -: 8];
   endfunction
   function automatic int idx(input int r, input int c);
      return 4*c + r;
   endfunction
   function automatic logic [7:0] get_byte(input logic [127:0] s, input int n);
      return s[127-8*n -: 8];
   endfunction
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         p = p ^ (b[i] ? x : 8'h00);
         x = xtime(x);
      end
      return p;
   endfunction
   // row r of every column rotates right by r columns
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*idx(r, c) -: 8] = get_byte(s, idx(r, (c - r + 4) % 4));
      return o;
   endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational inverse round; i_last skips InvMixColumns
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] i_state,
   input  logic [127:0] i_rk,
   input  logic         i_last,
   output logic [127:0] o_state
);
   logic [127:0] w_sr, w_sb, w_ark, w_mc;
   assign w_sr = inv_shift_rows(i_state);
   for (genvar n = 0; n < 16; n++) begin : g_sb
      assign w_sb[127-8*n -: 8] = inv_sbox(w_sr[127-8*n -: 8]);
   end
   assign w_ark = w_sb ^ i_rk;
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign w_mc[127-8*(4*c+r) -: 8] =
            gf_mul(get_byte(w_ark, 4*c + r), 8'h0e) ^
            gf_mul(get_byte(w_ark, 4*c + (r+1)%4), 8'h0b) ^
            gf_mul(get_byte(w_ark, 4*c + (r+2)%4), 8'h0d) ^
            gf_mul(get_byte(w_ark, 4*c + (r+3)%4), 8'h09);
      end
   end
   assign o_state = i_last ? w_ark : w_mc;
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES inverse cipher, one round per clock with valid/ready handshakes
module aes_inv_cipher_iter
   import aes_pkg::*;
#(
   parameter int NR = NR_128
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [127:0] i_in_block,
   output logic [3:0]   o_rk_idx,
   input  logic [127:0] i_rk,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [127:0] o_out_block
);
   inv_state_t   r_st;
   logic [3:0]   r_cnt;
   logic [127:0] r_state, r_out, w_next;
   logic         r_in_ready, r_out_valid;
   aes_inv_round u_round (
      .i_state (r_state),
      .i_rk    (i_rk),
      .i_last  (r_cnt == 4'd0),
      .o_state (w_next)
   );
   // the round counter doubles as the key index; it parks at NR outside ROUND
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st        <= ST_IDLE;
         r_cnt       <= 4'(NR);
         r_state     <= '0;
         r_out       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_st)
            ST_IDLE: if (i_in_valid) begin
               r_state    <= i_in_block ^ i_rk;
               r_cnt      <= 4'(NR - 1);
               r_in_ready <= 1'b0;
               r_st       <= ST_ROUND;
            end
            ST_ROUND: if (r_cnt == 4'd0) begin
               r_out       <= w_next;
               r_cnt       <= 4'(NR);
               r_out_valid <= 1'b1;
               r_st        <= ST_DONE;
            end else begin
               r_state <= w_next;
               r_cnt   <= r_cnt - 4'd1;
            end
            ST_DONE: if (i_out_ready) begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_st        <= ST_IDLE;
            end
            default: r_st <= ST_IDLE;
         endcase
      end
   end
   assign o_in_ready  = r_in_ready;
   assign o_out_valid = r_out_valid;
   assign o_out_block = r_out;
   assign o_rk_idx    = r_cnt;
endmodule
